instr_mem_loadable: RTL and testbench
=====================================

# instr_mem_loadable

Parametrised, loadable instruction memory for the single-cycle/pipelined LEGv8 core. It replaces the hard-coded program table with a RAM that clears itself to `BR XZR` on reset and accepts a program over a valid/ready load stream. It then serves word-indexed instruction fetches with one-cycle registered latency. It sits between the fetch stage (PC word index in, instruction out) and the test harness or boot loader.

## Interface
- `ADDR_W`, 16: fetch/load address width (word index).
- `DATA_W`, 32: instruction width.
- `DEPTH`, 64: number of words, 2 ≤ DEPTH ≤ 2^ADDR_W.
- `DEFAULT_WORD`, 32'hD600_03E0: fill and out-of-range value (`BR XZR`).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `load_start` in 1: begin a load at word 0; honoured only in RUN.
- `load_data` in DATA_W: word to write.
- `load_valid` in 1: load_data valid.
- `load_last` in 1: qualifies final beat.
- `load_ready` out 1: block accepts a beat; high only in LOAD.
- `load_count` out ADDR_W+1: words accepted by the most recent load.
- `busy` out 1: high in CLEAR or LOAD.
- `fetch_en` in 1: fetch request.
- `fetch_addr` in ADDR_W: word index.
- `fetch_data` out DATA_W: registered instruction.
- `fetch_valid` out 1: fetch_data valid this cycle.
- `fetch_err` out 1: the valid fetch was out of range.

## Operation
- States: CLEAR, RUN, LOAD.
- Reset forces CLEAR and zeroes the write pointer `wptr`.
- CLEAR:
  - Writes DEFAULT_WORD to mem[wptr] every cycle and increments wptr.
  - After writing word DEPTH-1, goes to RUN.
  - load_start and fetch_en are ignored.
- RUN:
  - `load_start`=1 → LOAD, wptr←0, load_count←0.
  - A fetch in the same cycle is still serviced.
- LOAD:
  - load_ready=1 while wptr < DEPTH.
  - Beat = load_valid & load_ready. Each beat writes mem[wptr]←load_data, increments wptr and load_count.
  - Exit to RUN after the beat carrying load_last, or after the beat written at wptr=DEPTH-1, whichever comes first.
  - Words not written keep their previous contents.
  - load_start is ignored. Beats arriving while load_ready=0 are dropped.
- Fetch, RUN only:
  - fetch_en with fetch_addr < DEPTH → next cycle fetch_data=mem[fetch_addr], fetch_valid=1, fetch_err=0.
  - fetch_addr ≥ DEPTH → fetch_data=DEFAULT_WORD, fetch_valid=1, fetch_err=1.
  - fetch_en in CLEAR or LOAD → fetch_valid=0 next cycle; fetch_data holds its value.
- Reads and writes never overlap (writes only in CLEAR/LOAD, reads only in RUN), so no bypass logic.
- Arithmetic:
  - wptr and load_count are ADDR_W+1 bits, so a count of DEPTH is representable.
  - Address compare is unsigned.

## Timing
- Reset values:
  - State CLEAR.
  - fetch_data=DEFAULT_WORD.
  - fetch_valid=0, fetch_err=0, load_ready=0.
  - load_count=0, busy=1.
- CLEAR lasts exactly DEPTH cycles after reset deasserts; busy falls on the following edge.
- Fetch latency: 1 cycle. fetch_valid is a per-request pulse, and back-to-back fetches sustain one per cycle.
- Load throughput: one word per cycle. load_ready falls the cycle after the terminating beat.
- Reset mid-load: abandons the load and re-enters CLEAR. The memory is fully re-cleared, and load_count←0.

## Structure
- Package `imem_pkg`:
  - State enum `imem_state_t` (CLEAR, RUN, LOAD).
  - Constant `BR_XZR` = 32'hD600_03E0.
- Sub-module `imem_array`: one synchronous write port, one synchronous read port, parametrised by DATA_W/DEPTH, no reset on storage.
- Top level contains the FSM, pointers, range check and output registers.

## Test plan
- Reset for 2 cycles, then wait: busy stays high for DEPTH=64 cycles. A fetch of addr 0 then returns 0xD60003E0 with fetch_valid=1, fetch_err=0.
- Load 10 words (word 0 = 0x910193E4, ADDI X4,XZR,100), load_last on beat 10:
  - load_count=10.
  - Fetch addr 0 → 0x910193E4.
  - Fetch addr 9 → beat 10 data.
  - Fetch addr 10 → 0xD60003E0.
- Load with load_valid toggled every other cycle, then fetch addrs 0..3 back-to-back: all words are correct, and fetch_valid stays high for 4 consecutive cycles.
- Overflow, DEPTH+3 beats with no load_last:
  - load_ready drops after beat 64, and the extra beats are dropped.
  - load_count=64; fetch addr 63 → beat 64 data.
- Fetch addr 64 and addr 0xFFFF → 0xD60003E0, fetch_err=1. Fetch during LOAD → fetch_valid=0.
- Reset asserted after 5 load beats → CLEAR. After 64 cycles, fetch addr 2 returns 0xD60003E0 and load_count=0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable LEGv8 instruction memory.
// Holds the controller state enum and the BR XZR fill word.
// No logic lives here; the top and array import it.
package imem_pkg;

  // CLEAR fills the RAM after reset, RUN serves fetches, LOAD accepts a program.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } imem_state_t;

  // BR XZR: branch to address zero, a safe "parking" instruction.
  localparam logic [31:0] BR_XZR = 32'hD600_03E0;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one synchronous read port.
// Latency: read data registered, valid one clock after re; write takes effect on the edge.
// Backpressure: none; the controller guarantees reads and writes never overlap.
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata holds last read.
module imem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  // Storage is deliberately not reset; the controller clears it word by word.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    // rdata only moves on a read so it holds between requests.
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: self-clears to BR XZR, takes a program over a valid/ready stream.
// Latency: fetch data one cycle after request; one load word accepted per cycle.
// Backpressure: load_ready high only in LOAD while room remains; beats without ready are dropped.
// Ports: clk, reset (sync, active-high); load_start/load_data/load_valid/load_last in,
//        load_ready/load_count/busy out; fetch_en/fetch_addr in, fetch_data/fetch_valid/fetch_err out.
module instr_mem_loadable
  import imem_pkg::*;
#(
  parameter int              ADDR_W       = 16,
  parameter int              DATA_W       = 32,
  parameter int              DEPTH        = 64,
  parameter logic [DATA_W-1:0] DEFAULT_WORD = DATA_W'(BR_XZR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  input  logic              load_last,
  output logic              load_ready,
  output logic [ADDR_W:0]   load_count,
  output logic              busy,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              fetch_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W + 1)'(DEPTH - 1);

  imem_state_t       state, state_nx;
  logic [ADDR_W:0]   wptr, wptr_nx;
  logic [ADDR_W:0]   count_nx;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic              in_range;
  logic              fetch_go;
  logic              sel_default;

  // Unsigned compare with a spare top bit so DEPTH == 2^ADDR_W still works.
  assign in_range = ({1'b0, fetch_addr} < DEPTH_C);
  assign fetch_go = (state == RUN) && fetch_en;
  assign busy     = (state != RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      wptr       <= '0;
      load_count <= '0;
    end else begin
      state      <= state_nx;
      wptr       <= wptr_nx;
      load_count <= count_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    wptr_nx    = wptr;
    count_nx   = load_count;
    mem_we     = 1'b0;
    mem_wdata  = DEFAULT_WORD;
    mem_re     = 1'b0;
    load_ready = 1'b0;
    case (state)
      CLEAR: begin
        mem_we  = 1'b1;
        wptr_nx = wptr + 1'b1;
        if (wptr == LAST_C) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        // Out-of-range fetches skip the RAM; the output mux supplies the fill word.
        mem_re = fetch_en && in_range;
        if (load_start) begin
          state_nx = LOAD;
          wptr_nx  = '0;
          count_nx = '0;
        end
      end
      LOAD: begin
        load_ready = (wptr < DEPTH_C);
        if (load_valid && load_ready) begin
          mem_we    = 1'b1;
          mem_wdata = load_data;
          wptr_nx   = wptr + 1'b1;
          count_nx  = load_count + 1'b1;
          if (load_last || (wptr == LAST_C)) begin
            state_nx = RUN;
          end
        end
      end
      default: begin
        state_nx = CLEAR;
        wptr_nx  = '0;
      end
    endcase
  end

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr[IDX_W-1:0]),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (fetch_addr[IDX_W-1:0]),
    .rdata (mem_rdata)
  );

  // sel_default remembers whether the latest serviced fetch was out of range,
  // so fetch_data holds its value across idle cycles and blocked fetches.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      sel_default <= 1'b1;
    end else begin
      fetch_valid <= fetch_go;
      fetch_err   <= fetch_go && !in_range;
      if (fetch_go) begin
        sel_default <= !in_range;
      end
    end
  end

  assign fetch_data = sel_default ? DEFAULT_WORD : mem_rdata;

endmodule

// File: tb/tb_instr_mem_loadable.sv
module tb_instr_mem_loadable;

  localparam int          DEPTH = 64;
  localparam logic [31:0] DFLT  = 32'hD600_03E0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_start = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_valid = 1'b0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic [16:0] load_count;
  logic        busy;
  logic        fetch_en = 1'b0;
  logic [15:0] fetch_addr = '0;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        fetch_err;

  int tests = 0;
  int fails = 0;

  instr_mem_loadable dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_count  (load_count),
    .busy        (busy),
    .fetch_en    (fetch_en),
    .fetch_addr  (fetch_addr),
    .fetch_data  (fetch_data),
    .fetch_valid (fetch_valid),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Mode: 0 clearing, 1 running, 2 loading.
  int          m_mode = 0;
  int          m_clear_left = 0;
  int          m_ptr = 0;
  int          m_count = 0;
  logic [31:0] m_mem [DEPTH];
  bit          m_on = 1'b0;
  logic [31:0] e_data = DFLT;
  bit          e_valid = 1'b0;
  bit          e_err = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_on = 1'b1;
      m_mode = 0;
      m_clear_left = DEPTH;
      m_count = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = DFLT;
      e_valid = 1'b0;
      e_err = 1'b0;
      e_data = DFLT;
    end else if (m_on) begin
      e_valid = 1'b0;
      e_err = 1'b0;
      if (m_mode == 0) begin
        m_clear_left--;
        if (m_clear_left == 0) m_mode = 1;
      end else if (m_mode == 1) begin
        if (fetch_en) begin
          e_valid = 1'b1;
          if (int'(fetch_addr) >= DEPTH) begin
            e_err = 1'b1;
            e_data = DFLT;
          end else begin
            e_data = m_mem[int'(fetch_addr)];
          end
        end
        if (load_start) begin
          m_mode = 2;
          m_ptr = 0;
          m_count = 0;
        end
      end else begin
        if (load_valid && m_ptr < DEPTH) begin
          m_mem[m_ptr] = load_data;
          m_ptr++;
          m_count++;
          if (load_last || m_ptr == DEPTH) m_mode = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("m_fetch_valid", 64'(fetch_valid), 64'(e_valid));
      chk("m_fetch_err", 64'(fetch_err), 64'(e_err));
      chk("m_fetch_data", 64'(fetch_data), 64'(e_data));
      chk("m_busy", 64'(busy), 64'(m_mode != 1));
      chk("m_load_ready", 64'(load_ready), 64'(m_mode == 2 && m_ptr < DEPTH));
      chk("m_load_count", 64'(load_count), 64'(m_count));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle(input string nm, output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 200) chk({nm, "_timeout"}, 64'(busy), 64'd0);
  endtask

  task automatic do_fetch(input logic [15:0] a, input logic [31:0] ed, input logic ee, input string nm);
    @(negedge clk);
    fetch_en = 1'b1;
    fetch_addr = a;
    @(negedge clk);
    fetch_en = 1'b0;
    chk({nm, "_data"}, 64'(fetch_data), 64'(ed));
    chk({nm, "_valid"}, 64'(fetch_valid), 64'd1);
    chk({nm, "_err"}, 64'(fetch_err), 64'(ee));
  endtask

  // Starts a load and streams n beats of base + i*0x11; returns beats presented with ready high.
  task automatic load_words(input int n, input bit last_on, input bit gap, input logic [31:0] base,
                            output int acc);
    acc = 0;
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data = base + 32'(i) * 32'h11;
      load_last = last_on && (i == n - 1);
      if (load_ready) acc++;
      @(negedge clk);
      if (gap) begin
        load_valid = 1'b0;
        load_last = 1'b0;
        @(negedge clk);
      end
    end
    load_valid = 1'b0;
    load_last = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int acc;
    int vcnt;

    // Reset for two cycles; outputs must show reset values.
    @(negedge clk);
    chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
    chk("rst_fetch_err", 64'(fetch_err), 64'd0);
    chk("rst_load_ready", 64'(load_ready), 64'd0);
    chk("rst_load_count", 64'(load_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_fetch_data", 64'(fetch_data), 64'(DFLT));
    @(negedge clk);
    reset = 1'b0;
    // Fetch requests during CLEAR must be ignored.
    fetch_en = 1'b1;
    wait_idle("clear", cyc);
    fetch_en = 1'b0;
    chk("clear_cycles", 64'(cyc), 64'd64);
    do_fetch(16'd0, DFLT, 1'b0, "post_clear_f0");

    // Ten-word program terminated by load_last.
    load_words(10, 1'b1, 1'b0, 32'h910193E4, acc);
    chk("load10_count", 64'(load_count), 64'd10);
    do_fetch(16'd0, 32'h910193E4, 1'b0, "load10_f0");
    do_fetch(16'd9, 32'h910193E4 + 32'h99, 1'b0, "load10_f9");
    do_fetch(16'd10, DFLT, 1'b0, "load10_f10");

    // Stream with gaps, then four back-to-back fetches.
    load_words(4, 1'b1, 1'b1, 32'h12340000, acc);
    chk("gap_count", 64'(load_count), 64'd4);
    @(negedge clk);
    fetch_en = 1'b1;
    fetch_addr = 16'd0;
    vcnt = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (fetch_valid) vcnt++;
      chk("b2b_data", 64'(fetch_data), 64'(32'h12340000 + 32'(i - 1) * 32'h11));
      if (i < 4) fetch_addr = 16'(i);
      else fetch_en = 1'b0;
    end
    chk("b2b_valid_run", 64'(vcnt), 64'd4);
    do_fetch(16'd4, 32'h910193E4 + 32'h44, 1'b0, "gap_untouched_f4");

    // Overflow: 67 beats, no load_last; only 64 accepted.
    load_words(DEPTH + 3, 1'b0, 1'b0, 32'hA0000000, acc);
    chk("ovf_accepted", 64'(acc), 64'd64);
    chk("ovf_count", 64'(load_count), 64'd64);
    chk("ovf_ready_low", 64'(load_ready), 64'd0);
    do_fetch(16'd63, 32'hA0000000 + 32'd63 * 32'h11, 1'b0, "ovf_f63");

    // Out-of-range fetches.
    do_fetch(16'd64, DFLT, 1'b1, "oor_f64");
    do_fetch(16'hFFFF, DFLT, 1'b1, "oor_fffff");
    do_fetch(16'd1, 32'hA0000011, 1'b0, "inrange_after_err");

    // Fetch while loading gets no response and fetch_data holds.
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    fetch_en = 1'b1;
    fetch_addr = 16'd0;
    load_valid = 1'b1;
    load_last = 1'b1;
    load_data = 32'hCAFEF00D;
    @(negedge clk);
    fetch_en = 1'b0;
    load_valid = 1'b0;
    load_last = 1'b0;
    chk("load_fetch_valid", 64'(fetch_valid), 64'd0);
    chk("load_fetch_hold", 64'(fetch_data), 64'hA0000011);
    do_fetch(16'd0, 32'hCAFEF00D, 1'b0, "single_beat_f0");

    // Reset in the middle of a load.
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data = 32'h55550000 + 32'(i);
      @(negedge clk);
    end
    load_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_idle("reclear", cyc);
    chk("reclear_cycles", 64'(cyc), 64'd64);
    do_fetch(16'd2, DFLT, 1'b0, "reclear_f2");
    chk("reclear_count", 64'(load_count), 64'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case anything stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
